// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command sequencer and its neighbours.
//   ALU_WIDTH / ALU_SEL_W : default operand and opcode widths of the ALU
//   ALU_ADD / ALU_SUB     : opcodes the external ALU uses for add / subtract
//   seq_state_e           : sequencer FSM states
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_WIDTH = 16;
    localparam int ALU_SEL_W = 4;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } seq_state_e;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
// Clocked driver for an external combinational ALU. A command is accepted
// over a valid/ready handshake, its operands are held on the ALU inputs for
// a settle period, the ALU result/carry are registered and returned over a
// valid/ready response. The last result is kept in an accumulator so a
// following command can use it as operand a.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready       command handshake
//   cmd_a, cmd_b, cmd_sel       operands and ALU opcode
//   cmd_use_acc                 take operand a from the accumulator
//   acc_clear                   synchronous accumulator clear
//   alu_a, alu_b, alu_sel       registered operands to the ALU
//   alu_result, alu_carry       combinational result from the ALU
//   rsp_valid / rsp_ready       response handshake
//   rsp_result, rsp_carry       captured ALU result and carry
//   op_count                    number of completed responses (wraps)
// ---------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH         = ALU_WIDTH,
    parameter int SEL_W         = ALU_SEL_W,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [SEL_W-1:0] cmd_sel,
    input  logic             cmd_use_acc,
    input  logic             acc_clear,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic [CNT_W-1:0] op_count
);

    localparam int SCW = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

    seq_state_e       state_q, state_d;
    logic [SCW-1:0]   settle_q, settle_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [SEL_W-1:0] opSel_q, opSel_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] rspResult_q, rspResult_d;
    logic             rspCarry_q, rspCarry_d;
    logic [CNT_W-1:0] opCount_q, opCount_d;
    logic             cmdReady_q, cmdReady_d;

    // cmd_ready is registered so it reads 0 throughout reset and rises on
    // the first clock after release.
    assign cmd_ready  = cmdReady_q;
    assign rsp_valid  = (state_q == ST_RESP);
    assign alu_a      = opA_q;
    assign alu_b      = opB_q;
    assign alu_sel    = opSel_q;
    assign rsp_result = rspResult_q;
    assign rsp_carry  = rspCarry_q;
    assign op_count   = opCount_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            opA_q       <= '0;
            opB_q       <= '0;
            opSel_q     <= '0;
            acc_q       <= '0;
            rspResult_q <= '0;
            rspCarry_q  <= 1'b0;
            opCount_q   <= '0;
            cmdReady_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            opSel_q     <= opSel_d;
            acc_q       <= acc_d;
            rspResult_q <= rspResult_d;
            rspCarry_q  <= rspCarry_d;
            opCount_q   <= opCount_d;
            cmdReady_q  <= cmdReady_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        opSel_d     = opSel_q;
        rspResult_d = rspResult_q;
        rspCarry_d  = rspCarry_q;
        opCount_d   = opCount_q;
        // A clear applies in any state; the capture below overrides it.
        acc_d       = acc_clear ? '0 : acc_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmdReady_q) begin
                    // acc_q is the pre-clear value even if acc_clear is high now.
                    opA_d    = cmd_use_acc ? acc_q : cmd_a;
                    opB_d    = cmd_b;
                    opSel_d  = cmd_sel;
                    settle_d = SCW'(SETTLE_CYCLES);
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_q == '0) begin
                    state_d = ST_CAPTURE;
                end else begin
                    settle_d = settle_q - SCW'(1);
                end
            end
            ST_CAPTURE: begin
                rspResult_d = alu_result;
                rspCarry_d  = alu_carry;
                acc_d       = alu_result;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    opCount_d = opCount_q + CNT_W'(1);
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmdReady_d = (state_d == ST_IDLE);
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
// Self-checking bench for alu_cmd_sequencer. Provides a behavioural ALU on
// the alu_* ports, a transaction-level reference model of the sequencer,
// a per-cycle compare process, directed scenarios and a randomized phase.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int WIDTH  = 16;
    localparam int SEL_W  = 4;
    localparam int SETTLE = 1;
    localparam int CNT_W  = 4;

    logic             clk = 1'b0;
    logic             rstN = 1'b0;
    logic             cmdValid = 1'b0;
    logic             cmdReady;
    logic [WIDTH-1:0] cmdA = '0;
    logic [WIDTH-1:0] cmdB = '0;
    logic [SEL_W-1:0] cmdSel = '0;
    logic             cmdUseAcc = 1'b0;
    logic             accClear = 1'b0;
    logic [WIDTH-1:0] aluA, aluB, aluResult;
    logic [SEL_W-1:0] aluSel;
    logic             aluCarry;
    logic             rspValid;
    logic             rspReady = 1'b0;
    logic [WIDTH-1:0] rspResult;
    logic             rspCarry;
    logic [CNT_W-1:0] opCount;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(
        .WIDTH(WIDTH), .SEL_W(SEL_W), .SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rstN),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady),
        .cmd_a(cmdA), .cmd_b(cmdB), .cmd_sel(cmdSel),
        .cmd_use_acc(cmdUseAcc), .acc_clear(accClear),
        .alu_a(aluA), .alu_b(aluB), .alu_sel(aluSel),
        .alu_result(aluResult), .alu_carry(aluCarry),
        .rsp_valid(rspValid), .rsp_ready(rspReady),
        .rsp_result(rspResult), .rsp_carry(rspCarry),
        .op_count(opCount)
    );

    // Behavioural stand-in for the external ALU: {carry, result}.
    function automatic logic [16:0] aluFn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] sel);
        case (sel)
            ALU_ADD: return {1'b0, a} + {1'b0, b};
            ALU_SUB: return {1'b0, a} + {1'b0, ~b} + 17'd1;
            4'd2:    return {1'b0, a & b};
            4'd3:    return {1'b0, a | b};
            4'd4:    return {1'b0, a ^ b};
            default: return {1'b0, a};
        endcase
    endfunction

    always_comb {aluCarry, aluResult} = aluFn(aluA, aluB, aluSel);

    // Reference model: one outstanding transaction, response due a fixed
    // number of edges after acceptance, accumulator follows results.
    int               edgeCnt = 0;
    bit               mBusy, mValid, mReady;
    int               mAcceptEdge;
    logic [WIDTH-1:0] mAcc, mAluA, mAluB, mResult, mPendRes;
    logic [SEL_W-1:0] mAluSel;
    logic             mCarry, mPendCarry;
    int               mCount;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mBusy = 0; mValid = 0; mReady = 0; mAcceptEdge = 0;
            mAcc = '0; mAluA = '0; mAluB = '0; mAluSel = '0;
            mResult = '0; mCarry = 1'b0; mPendRes = '0; mPendCarry = 1'b0;
            mCount = 0;
        end else begin
            bit captured;
            captured = 0;
            edgeCnt++;
            if (mBusy && !mValid && edgeCnt == mAcceptEdge + SETTLE + 2) begin
                mResult  = mPendRes;
                mCarry   = mPendCarry;
                mAcc     = mPendRes;
                mValid   = 1;
                captured = 1;
            end else if (mValid && rspReady) begin
                mValid = 0;
                mBusy  = 0;
                mCount = (mCount + 1) % (1 << CNT_W);
            end else if (!mBusy && mReady && cmdValid) begin
                mBusy       = 1;
                mAcceptEdge = edgeCnt;
                mAluA       = cmdUseAcc ? mAcc : cmdA;
                mAluB       = cmdB;
                mAluSel     = cmdSel;
                {mPendCarry, mPendRes} = aluFn(mAluA, mAluB, mAluSel);
            end
            if (accClear && !captured) mAcc = '0;
            mReady = !mBusy;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the reference model.
    always @(negedge clk) begin
        checkOutput("cmd_ready", 32'(cmdReady), 32'(mReady));
        checkOutput("rsp_valid", 32'(rspValid), 32'(mValid));
        checkOutput("op_count", 32'(opCount), 32'(mCount));
        checkOutput("alu_a", 32'(aluA), 32'(mAluA));
        checkOutput("alu_b", 32'(aluB), 32'(mAluB));
        checkOutput("alu_sel", 32'(aluSel), 32'(mAluSel));
        if (mValid) begin
            checkOutput("rsp_result", 32'(rspResult), 32'(mResult));
            checkOutput("rsp_carry", 32'(rspCarry), 32'(mCarry));
        end
    end

    // Issues one command with rsp_ready held high and returns the response
    // and the number of clocks from acceptance to rsp_valid.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic [3:0] sel, input logic useAcc,
                                 output logic [15:0] res, output logic carry, output int lat);
        int n;
        @(posedge clk); #1;
        cmdValid = 1'b1; cmdA = a; cmdB = b; cmdSel = sel; cmdUseAcc = useAcc; rspReady = 1'b1;
        n = 0;
        @(negedge clk);
        while (cmdReady !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        if (n >= 40) checkOutput("accept timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        cmdValid = 1'b0;
        lat = 0;
        while (rspValid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
        if (lat >= 40) checkOutput("response timeout", 32'd0, 32'd1);
        res   = rspResult;
        carry = rspCarry;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] res;
        logic        c;
        int          lat, n;

        #2;
        checkOutput("reset cmd_ready", 32'(cmdReady), 32'd0);
        checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("reset op_count", 32'(opCount), 32'd0);
        checkOutput("reset alu_a", 32'(aluA), 32'd0);
        #21 rstN = 1'b1;
        @(posedge clk); #1;
        checkOutput("ready after reset", 32'(cmdReady), 32'd1);

        // T1: plain add, latency and count
        applyStimulus(16'd10, 16'd6, ALU_ADD, 1'b0, res, c, lat);
        checkOutput("T1 result", 32'(res), 32'd16);
        checkOutput("T1 carry", 32'(c), 32'd0);
        checkOutput("T1 latency", 32'(lat), 32'd3);
        checkOutput("T1 op_count", 32'(opCount), 32'd1);

        // T2: carry out, accumulator becomes 0
        applyStimulus(16'hFFFF, 16'd1, ALU_ADD, 1'b0, res, c, lat);
        checkOutput("T2 result", 32'(res), 32'd0);
        checkOutput("T2 carry", 32'(c), 32'd1);
        applyStimulus(16'h1234, 16'd0, ALU_ADD, 1'b1, res, c, lat);
        checkOutput("T2 acc zero", 32'(res), 32'd0);

        applyStimulus(16'd10, 16'd6, ALU_SUB, 1'b0, res, c, lat);
        checkOutput("sub result", 32'(res), 32'd4);

        // T3: chained through the accumulator
        applyStimulus(16'd10, 16'd6, ALU_ADD, 1'b0, res, c, lat);
        checkOutput("T3 first", 32'(res), 32'd16);
        applyStimulus(16'd999, 16'd4, ALU_ADD, 1'b1, res, c, lat);
        checkOutput("T3 chained", 32'(res), 32'd20);

        // T4: back-pressure on the response
        @(posedge clk); #1;
        cmdValid = 1'b1; cmdA = 16'd100; cmdB = 16'd23; cmdSel = ALU_ADD; cmdUseAcc = 1'b0;
        rspReady = 1'b0;
        n = 0;
        @(negedge clk);
        while (cmdReady !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        cmdA = 16'd555;
        n = 0;
        while (rspValid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("T4 rsp_valid held", 32'(rspValid), 32'd1);
            checkOutput("T4 result held", 32'(rspResult), 32'd123);
            checkOutput("T4 cmd_ready low", 32'(cmdReady), 32'd0);
        end
        cmdValid = 1'b0; rspReady = 1'b1;
        @(posedge clk); #1;
        checkOutput("T4 rsp_valid drop", 32'(rspValid), 32'd0);

        // T5: reset while the ALU operands are being driven
        cmdValid = 1'b1; cmdA = 16'd500; cmdB = 16'd5; cmdSel = ALU_ADD;
        n = 0;
        @(negedge clk);
        while (cmdReady !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        @(posedge clk); #1;
        cmdValid = 1'b0;
        #2 rstN = 1'b0;
        #1;
        checkOutput("T5 alu_a", 32'(aluA), 32'd0);
        checkOutput("T5 rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("T5 cmd_ready", 32'(cmdReady), 32'd0);
        checkOutput("T5 op_count", 32'(opCount), 32'd0);
        #2 rstN = 1'b1;
        applyStimulus(16'd999, 16'd7, ALU_ADD, 1'b1, res, c, lat);
        checkOutput("T5 acc cleared", 32'(res), 32'd7);
        checkOutput("T5 count restart", 32'(opCount), 32'd1);

        // T6: op_count wrap
        for (int i = 0; i < 14; i++) applyStimulus(16'(i), 16'd1, ALU_ADD, 1'b0, res, c, lat);
        checkOutput("T6 count 15", 32'(opCount), 32'd15);
        applyStimulus(16'd1, 16'd1, ALU_ADD, 1'b0, res, c, lat);
        checkOutput("T6 count wrap", 32'(opCount), 32'd0);

        // Randomized traffic checked by the compare process
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            cmdValid  = ($urandom_range(0, 3) != 0);
            rspReady  = ($urandom_range(0, 9) < 7);
            accClear  = ($urandom_range(0, 7) == 0);
            cmdUseAcc = $urandom_range(0, 1) != 0;
            cmdSel    = 4'($urandom_range(0, 5));
            cmdA      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            cmdB      = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        end
        @(posedge clk); #1;
        cmdValid = 1'b0; rspReady = 1'b1; accClear = 1'b0;
        repeat (12) @(posedge clk);
        #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
